// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// The BYZERO state exists only when DIV_ZERO_CHECK_EN is defined.
package div_unit_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [63:0] DoubleReg_t;

  localparam int unsigned DIV_ITER_CNT = 32;

  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

`ifdef DIV_ZERO_CHECK_EN
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } div_state_e;
`else
  typedef enum logic [1:0] {
    FREE = 2'b00,
    ON   = 2'b10,
    END  = 2'b11
  } div_state_e;
`endif

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider, one quotient bit per clock.
// result_o = {remainder, quotient}, valid for the single cycle ready_o is high.
// Optional feature macro: DIV_ZERO_CHECK_EN -- short-circuits a zero divisor
// through BYZERO and returns an all-zero result two edges after accept.
//
// state  | meaning
// -------+------------------------------------------------------------
// FREE   | idle, waiting for start_i (start with annul_i is dropped)
// BYZERO | zero divisor seen, result forced to 0 (macro builds only)
// ON     | one restoring-division iteration per edge, 32 in total
// END    | result_o valid, ready_o high for this one cycle
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       signed_i,
  input  Reg_t       opdata1_i,
  input  Reg_t       opdata2_i,
  input  logic       annul_i,
  output DoubleReg_t result_o,
  output logic       ready_o
);

  localparam logic [5:0] LAST_CNT = 6'(DIV_ITER_CNT - 1);

  div_state_e state_q, state_d;
  logic [5:0] cnt_q;
  Reg_t       dvd_q;      // dividend bits shift out the top, quotient bits shift in
  Reg_t       dvs_q;
  Reg_t       rem_q;
  logic       neg_quo_q;
  logic       neg_rem_q;

  logic        accept;
  logic        zero_div;
  Reg_t        op1_abs, op2_abs;
  logic [32:0] partial, trial;
  logic        ge;
  Reg_t        rem_next, dvd_next;
  Reg_t        quo_fix, rem_fix;

  assign accept = start_i && !annul_i;

`ifdef DIV_ZERO_CHECK_EN
  assign zero_div = (opdata2_i == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Operand magnitudes; 0x80000000 maps onto itself, which is still the right unsigned magnitude.
  always_comb begin
    op1_abs = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_abs = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    partial  = {rem_q, dvd_q[31]};
    trial    = partial - {1'b0, dvs_q};
    ge       = (partial >= {1'b0, dvs_q});
    rem_next = ge ? trial[31:0] : partial[31:0];
    dvd_next = {dvd_q[30:0], ge};
  end

  // Sign fix-up of the magnitude result: quotient by sign xor, remainder follows the dividend.
  always_comb begin
    quo_fix = neg_quo_q ? (~dvd_q + 32'd1) : dvd_q;
    rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FREE;
    else     state_q <= state_d;
  end

  // Next-state decode and outputs; outputs are zero outside END.
  always_comb begin
    state_d  = state_q;
    ready_o  = DIV_NOT_READY;
    result_o = '0;
    case (state_q)
      FREE: begin
        if (accept) begin
`ifdef DIV_ZERO_CHECK_EN
          state_d = zero_div ? BYZERO : ON;
`else
          state_d = ON;
`endif
        end
      end
`ifdef DIV_ZERO_CHECK_EN
      BYZERO: state_d = annul_i ? FREE : END;
`endif
      ON: begin
        if (annul_i)                state_d = FREE;
        else if (cnt_q == LAST_CNT) state_d = END;
      end
      END: begin
        state_d  = FREE;
        ready_o  = DIV_READY;
        result_o = {rem_fix, quo_fix};
      end
      default: state_d = FREE;
    endcase
  end

  // Datapath: latch operands on accept, iterate while ON, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (accept) begin
            cnt_q <= '0;
            rem_q <= '0;
            if (zero_div) begin
              dvd_q     <= '0;
              dvs_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end else begin
              dvd_q     <= op1_abs;
              dvs_q     <= op2_abs;
              neg_quo_q <= signed_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem_q <= signed_i && opdata1_i[31];
            end
          end
        end
        ON: begin
          if (!annul_i) begin
            dvd_q <= dvd_next;
            rem_q <= rem_next;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, randomized operands
// against an arithmetic reference, annul / reset / held-start scenarios.
module tb_div_unit;
  import div_unit_pkg::*;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       signed_i;
  Reg_t       opdata1_i;
  Reg_t       opdata2_i;
  logic       annul_i;
  DoubleReg_t result_o;
  logic       ready_o;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Reference: plain integer division.
  function automatic DoubleReg_t model(Reg_t a, Reg_t b, logic sg);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      if (ZC) return '0;
      return {a, 32'hFFFF_FFFF};
    end
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int model_lat(Reg_t b);
    return (ZC && b == 32'd0) ? 2 : 33;
  endfunction

  function automatic Reg_t pick(logic allow_zero);
    Reg_t v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = Reg_t'($urandom_range(0, 40));
      2: case ($urandom_range(0, 4))
           0: v = 32'h0000_0000;
           1: v = 32'h0000_0001;
           2: v = 32'hFFFF_FFFF;
           3: v = 32'h8000_0000;
           default: v = 32'h7FFF_FFFF;
         endcase
      default: v = Reg_t'($urandom) >> $urandom_range(0, 31);
    endcase
    if (!allow_zero && v == 32'd0) v = 32'd3;
    return v;
  endfunction

  // Issue one operation and follow it to its ready pulse, scrambling operands after accept.
  task automatic do_op(input Reg_t a, input Reg_t b, input logic sg,
                       output DoubleReg_t res, output int lat,
                       output logic busy_bad, output logic extra);
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_i = sg; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk);
    lat = 1; busy_bad = 1'b0; extra = 1'b0; res = '0;
    @(negedge clk);
    start_i = 1'b0;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_i = 1'($urandom);
    while (!ready_o && lat < 100) begin
      if (result_o !== '0) busy_bad = 1'b1;
      @(posedge clk); lat++;
      @(negedge clk);
      opdata1_i = $urandom; opdata2_i = $urandom;
    end
    res = result_o;
    @(posedge clk);
    @(negedge clk);
    extra = ready_o;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
  endtask

  task automatic test_reset;
    int pulses;
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b, required 0", ready_o); end
    n_cmp++;
    if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h, required 0", result_o); end
    rst = 1'b0; start_i = 1'b0;
    count_pulses(40, pulses);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL reset_start_ignored: got %0d pulses, required 0", pulses); end
  endtask

  task automatic test_directed;
    Reg_t       a  [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd1000};
    Reg_t       b  [5] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3};
    logic       sg [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    DoubleReg_t exp[5] = '{ {32'h2, 32'hE}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                            {32'h0, 32'h8000_0000}, (ZC ? 64'd0 : {32'h5, 32'hFFFF_FFFF}),
                            {32'h1, 32'd333} };
    int         elat[5] = '{33, 33, 33, (ZC ? 2 : 33), 33};
    DoubleReg_t res;
    int         lat;
    logic       busy_bad, extra;
    for (int i = 0; i < 5; i++) begin
      do_op(a[i], b[i], sg[i], res, lat, busy_bad, extra);
      n_cmp++;
      if (res !== exp[i]) begin n_bad++; $display("FAIL directed_result[%0d]: got %h, required %h", i, res, exp[i]); end
      n_cmp++;
      if (lat !== elat[i]) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, elat[i]); end
      n_cmp++;
      if (busy_bad !== 1'b0 || extra !== 1'b0) begin
        n_bad++; $display("FAIL directed_outputs_idle[%0d]: got busy_nonzero=%b extra_ready=%b, required 0 0", i, busy_bad, extra);
      end
    end
  endtask

  task automatic test_random(input logic sg, input int n);
    DoubleReg_t res, exp;
    Reg_t       a, b;
    int         lat;
    logic       busy_bad, extra;
    for (int i = 0; i < n; i++) begin
      a = pick(1'b1);
      b = pick(!sg || ZC);
      exp = model(a, b, sg);
      do_op(a, b, sg, res, lat, busy_bad, extra);
      n_cmp++;
      if (res !== exp) begin n_bad++; $display("FAIL random_result s=%b %h/%h: got %h, required %h", sg, a, b, res, exp); end
      n_cmp++;
      if (lat !== model_lat(b)) begin n_bad++; $display("FAIL random_latency %h/%h: got %0d, required %0d", a, b, lat, model_lat(b)); end
      n_cmp++;
      if (busy_bad !== 1'b0 || extra !== 1'b0) begin
        n_bad++; $display("FAIL random_outputs_idle %h/%h: got busy_nonzero=%b extra_ready=%b, required 0 0", a, b, busy_bad, extra);
      end
    end
  endtask

  task automatic test_annul;
    int         pulses, lat;
    DoubleReg_t res;
    logic       busy_bad, extra;
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_i = 1'b0; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk);
    @(negedge clk); start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk); annul_i = 1'b0;
    count_pulses(40, pulses);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL annul_on: got %0d pulses, required 0", pulses); end
    do_op(32'd9, 32'd3, 1'b0, res, lat, busy_bad, extra);
    n_cmp++;
    if (res !== {32'h0, 32'h3}) begin n_bad++; $display("FAIL annul_followup_result: got %h, required 0000000000000003", res); end
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL annul_followup_latency: got %0d, required 33", lat); end
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk);
    @(negedge clk); start_i = 1'b0; annul_i = 1'b0;
    count_pulses(40, pulses);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL annul_start_free: got %0d pulses, required 0", pulses); end
`ifdef DIV_ZERO_CHECK_EN
    @(negedge clk);
    start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
    @(posedge clk);
    @(negedge clk); start_i = 1'b0; annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk); annul_i = 1'b0;
    count_pulses(40, pulses);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL annul_byzero: got %0d pulses, required 0", pulses); end
`endif
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_i = 1'b0; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk);
    @(negedge clk); start_i = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1; start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got ready=%b result=%h, required 0 0", ready_o, result_o);
    end
    count_pulses(40, pulses);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL reset_mid_no_pulse: got %0d pulses, required 0", pulses); end
  endtask

  task automatic test_start_held;
    int         pulses, cyc, first_lat;
    DoubleReg_t res;
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_i = 1'b0; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk);
    cyc = 1; pulses = 0; first_lat = 0; res = '0;
    repeat (44) begin
      @(negedge clk);
      if (ready_o) begin
        pulses++;
        if (pulses == 1) begin first_lat = cyc; res = result_o; end
      end
      opdata1_i = $urandom; opdata2_i = $urandom;
      if (cyc >= 31) start_i = 1'b0;
      @(posedge clk); cyc++;
    end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL start_held_pulses: got %0d, required 1", pulses); end
    n_cmp++;
    if (first_lat !== 33) begin n_bad++; $display("FAIL start_held_latency: got %0d, required 33", first_lat); end
    n_cmp++;
    if (res !== {32'h1, 32'd333}) begin n_bad++; $display("FAIL start_held_result: got %h, required %h", res, {32'h1, 32'd333}); end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    test_reset();
    test_directed();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    test_annul();
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
